exmem_skid_stage: RTL and testbench

- Parametrised EX/MEM pipeline stage with a valid/ready handshake and a 2-entry skid buffer.
- Carries the control and data bundle from Execute to Memory. Stalls propagate back without a combinational ready path.
- Supports flush (bubble insertion) and gates side-effecting controls on invalid beats.
- Saturating stall-cycle counter for performance debug.

---
 rtl/exmem_skid_stage.sv | 151 +++++++++++++++
 tb/tb_exmem_skid_stage.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/exmem_skid_stage.sv
// EX/MEM pipeline register with valid/ready handshake and a two-entry skid buffer.
// ReadyE is registered, so backpressure never forms a combinational path to Execute.
module exmem_skid_stage #(
    parameter int DATA_WIDTH       = 32,
    parameter int PC_WIDTH         = 32,
    parameter int REG_ADDR_WIDTH   = 5,
    parameter int RESULT_SRC_WIDTH = 2,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ValidE,
    output logic                        ReadyE,
    input  logic                        FlushM,
    input  logic                        RegWriteE,
    input  logic [RESULT_SRC_WIDTH-1:0] ResultSrcE,
    input  logic                        MemWriteE,
    input  logic [DATA_WIDTH-1:0]       ALUOutE,
    input  logic [DATA_WIDTH-1:0]       WriteDataE,
    input  logic [REG_ADDR_WIDTH-1:0]   RDE,
    input  logic [PC_WIDTH-1:0]         PCPlus4E,
    output logic                        ValidM,
    input  logic                        ReadyM,
    output logic                        RegWriteM,
    output logic [RESULT_SRC_WIDTH-1:0] ResultSrcM,
    output logic                        MemWriteM,
    output logic [DATA_WIDTH-1:0]       ALUOutM,
    output logic [DATA_WIDTH-1:0]       WriteDataM,
    output logic [REG_ADDR_WIDTH-1:0]   RDM,
    output logic [PC_WIDTH-1:0]         PCPlus4M,
    output logic [CNT_WIDTH-1:0]        StallCount
);

    typedef struct packed {
        logic                        reg_write;
        logic [RESULT_SRC_WIDTH-1:0] result_src;
        logic                        mem_write;
        logic [DATA_WIDTH-1:0]       alu_out;
        logic [DATA_WIDTH-1:0]       write_data;
        logic [REG_ADDR_WIDTH-1:0]   rd;
        logic [PC_WIDTH-1:0]         pc_plus4;
    } bundle_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_e               state_q, state_d;
    bundle_t              main_q, main_d;
    bundle_t              skid_q, skid_d;
    logic                 ready_q, ready_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    bundle_t in_bundle;
    logic    valid_m;
    logic    in_fire;
    logic    out_fire;

    assign in_bundle = '{
        reg_write:  RegWriteE,
        result_src: ResultSrcE,
        mem_write:  MemWriteE,
        alu_out:    ALUOutE,
        write_data: WriteDataE,
        rd:         RDE,
        pc_plus4:   PCPlus4E
    };

    assign valid_m  = (state_q != ST_EMPTY);
    assign in_fire  = ValidE & ready_q;
    assign out_fire = valid_m & ReadyM;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d     = state_q;
        main_d      = main_q;
        skid_d      = skid_q;
        stall_cnt_d = stall_cnt_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d = ST_ONE;
                    main_d  = in_bundle;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_d = in_bundle;
                end else if (in_fire) begin
                    state_d = ST_FULL;
                    skid_d  = in_bundle;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // Flush only kills occupancy; stale data left in the registers is masked by ValidM.
        if (FlushM) begin
            state_d = ST_EMPTY;
        end

        ready_d = (state_d != ST_FULL);

        if (ValidE && !ready_q && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rst_n) begin
            // NOTE: both bundle registers are cleared, so observable M outputs and skid contents are defined after reset.
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            ready_q     <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            ready_q     <= ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ReadyE     = ready_q;
    assign ValidM     = valid_m;
    assign RegWriteM  = main_q.reg_write & valid_m;
    assign MemWriteM  = main_q.mem_write & valid_m;
    assign ResultSrcM = main_q.result_src;
    assign ALUOutM    = main_q.alu_out;
    assign WriteDataM = main_q.write_data;
    assign RDM        = main_q.rd;
    assign PCPlus4M   = main_q.pc_plus4;
    assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_exmem_skid_stage.sv
// Directed bench for exmem_skid_stage: streaming, backpressure, flush, reset, saturation, gating.
module tb_exmem_skid_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ValidE, ReadyE, FlushM;
    logic        RegWriteE, MemWriteE;
    logic [1:0]  ResultSrcE;
    logic [31:0] ALUOutE, WriteDataE, PCPlus4E;
    logic [4:0]  RDE;
    logic        ValidM, ReadyM, RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUOutM, WriteDataM, PCPlus4M;
    logic [4:0]  RDM;
    logic [3:0]  StallCount;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    exmem_skid_stage #(.CNT_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .ValidE(ValidE), .ReadyE(ReadyE), .FlushM(FlushM),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .ALUOutE(ALUOutE), .WriteDataE(WriteDataE), .RDE(RDE), .PCPlus4E(PCPlus4E),
        .ValidM(ValidM), .ReadyM(ReadyM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .MemWriteM(MemWriteM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .RDM(RDM),
        .PCPlus4M(PCPlus4M), .StallCount(StallCount)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; ValidE = 1'b0; FlushM = 1'b0; ReadyM = 1'b0;
        RegWriteE = 1'b0; MemWriteE = 1'b0; ResultSrcE = 2'd0;
        ALUOutE = '0; WriteDataE = '0; RDE = '0; PCPlus4E = '0;
        tick();
        check("rst_valid", ValidM, 0);
        check("rst_ready", ReadyE, 1);
        check("rst_cnt", StallCount, 0);
        check("rst_alu", ALUOutM, 0);
        check("rst_pc", PCPlus4M, 0);
        check("rst_regw", RegWriteM, 0);

        // Invalid gating: write enables high but no valid beat.
        rst_n = 1'b1; RegWriteE = 1'b1; MemWriteE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("gate_valid", ValidM, 0);
            check("gate_regw", RegWriteM, 0);
            check("gate_memw", MemWriteM, 0);
        end

        // Streaming at full throughput.
        MemWriteE = 1'b0; ReadyM = 1'b1; ValidE = 1'b1;
        ALUOutE = 32'h10; tick();
        check("str0_valid", ValidM, 1);
        check("str0_alu", ALUOutM, 32'h10);
        check("str0_regw", RegWriteM, 1);
        check("str0_ready", ReadyE, 1);
        ALUOutE = 32'h20; tick();
        check("str1_alu", ALUOutM, 32'h20);
        check("str1_ready", ReadyE, 1);
        ALUOutE = 32'h30; tick();
        check("str2_alu", ALUOutM, 32'h30);
        check("str2_valid", ValidM, 1);
        ValidE = 1'b0; tick();
        check("str_drain", ValidM, 0);

        // Backpressure fill then drain.
        ReadyM = 1'b0; ValidE = 1'b1; RDE = 5'd3; tick();
        check("bp0_valid", ValidM, 1);
        check("bp0_rd", RDM, 3);
        check("bp0_ready", ReadyE, 1);
        RDE = 5'd7; tick();
        check("bp1_rd", RDM, 3);
        check("bp1_ready", ReadyE, 0);
        check("bp1_cnt", StallCount, 0);
        RDE = 5'd9; tick();
        check("bp2_cnt", StallCount, 1);
        tick();
        check("bp3_cnt", StallCount, 2);
        check("bp3_rd", RDM, 3);
        ValidE = 1'b0; ReadyM = 1'b1; tick();
        check("bp4_rd", RDM, 7);
        check("bp4_ready", ReadyE, 1);
        check("bp4_cnt", StallCount, 2);
        tick();
        check("bp5_valid", ValidM, 0);

        // Flush while FULL with store beats; the beat presented alongside flush must vanish.
        ReadyM = 1'b0; ValidE = 1'b1; MemWriteE = 1'b1; RDE = 5'd1; tick();
        RDE = 5'd2; tick();
        check("fl0_memw", MemWriteM, 1);
        check("fl0_ready", ReadyE, 0);
        FlushM = 1'b1; RDE = 5'd5; tick();
        check("fl1_valid", ValidM, 0);
        check("fl1_memw", MemWriteM, 0);
        check("fl1_ready", ReadyE, 1);
        check("fl1_cnt", StallCount, 3);
        FlushM = 1'b0; ValidE = 1'b0; MemWriteE = 1'b0; ReadyM = 1'b1; tick();
        check("fl2_valid", ValidM, 0);
        tick();
        check("fl3_valid", ValidM, 0);

        // Reset mid-stream while holding a register-writing beat.
        ReadyM = 1'b0; ValidE = 1'b1; RegWriteE = 1'b1; PCPlus4E = 32'h104; tick();
        check("rm0_valid", ValidM, 1);
        check("rm0_regw", RegWriteM, 1);
        check("rm0_pc", PCPlus4M, 32'h104);
        ValidE = 1'b0; rst_n = 1'b0; tick();
        check("rm1_valid", ValidM, 0);
        check("rm1_regw", RegWriteM, 0);
        check("rm1_pc", PCPlus4M, 0);
        check("rm1_cnt", StallCount, 0);
        check("rm1_ready", ReadyE, 1);
        rst_n = 1'b1; ValidE = 1'b1; PCPlus4E = 32'h200; tick();
        check("rm2_valid", ValidM, 1);
        check("rm2_pc", PCPlus4M, 32'h200);

        // Counter saturation: fill, then keep presenting beats for 20 stalled cycles.
        PCPlus4E = 32'h204; tick();
        check("sat_ready", ReadyE, 0);
        check("sat_cnt0", StallCount, 0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            check($sformatf("sat_cnt%0d", i), StallCount, (i > 15) ? 32'd15 : 32'(i));
        end
        check("sat_hold_pc", PCPlus4M, 32'h200);
        ValidE = 1'b0; ReadyM = 1'b1; tick();
        check("sat_drain_pc", PCPlus4M, 32'h204);
        check("sat_drain_cnt", StallCount, 15);
        tick();
        check("sat_empty", ValidM, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
